// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic {ST_IDLE, ST_WAIT} arb_state_e;

   typedef enum logic {OWN_IF = 1'b0, OWN_LSU = 1'b1} arb_owner_e;

   // Width of the IF starvation counter; wide enough for limits up to 15.
   localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_mux221.sv
// Plain 2:1 multiplexer used to steer the memory address; sel_i=1 picks in2_i.
module mux221 #(
   parameter int W = 32
) (
   input  logic [W-1:0] in1_i,
   input  logic [W-1:0] in2_i,
   input  logic         sel_i,
   output logic [W-1:0] out_o
);

   assign out_o = sel_i ? in2_i : in1_i;

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. LSU has priority, but a waiting IF is forced through after
// STARVE_MAX consecutive lost arbitrations. One transaction outstanding max.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                lsu_req_i,
   input  logic                lsu_we_i,
   input  logic [ADDR_W-1:0]   lsu_addr_i,
   input  logic [DATA_W-1:0]   lsu_wdata_i,
   input  logic [DATA_W/8-1:0] lsu_bmask_i,
   output logic                lsu_gnt_o,
   output logic                lsu_rvalid_o,
   output logic [DATA_W-1:0]   lsu_rdata_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_bmask_o,
   output logic                sel_o,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   arb_state_e          state_q, state_d;
   arb_owner_e          own_q, own_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic          any_req;
   logic          issue_ok;
   logic          issuing;
   logic          if_forced;
   arb_owner_e    winner;
   logic          sel_w;
   logic [ADDR_W-1:0] addr_mux;

   // A new command may go out when idle, or in the cycle the current one completes.
   assign any_req   = if_req_i | lsu_req_i;
   assign issue_ok  = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && mem_rvalid_i);
   assign issuing   = issue_ok & any_req;
   assign if_forced = if_req_i && (starve_q == STARVE_LIM);
   assign winner    = (lsu_req_i && !if_forced) ? OWN_LSU : OWN_IF;

   // Steering select follows the winner while issuing, otherwise the current owner.
   assign sel_w = issuing ? winner : own_q;
   assign sel_o = rst_ni & sel_w;

   mux221 #(
      .W(ADDR_W)
   ) u_addr_mux (
      .in1_i (if_addr_i),
      .in2_i (lsu_addr_i),
      .sel_i (sel_o),
      .out_o (addr_mux)
   );

   assign mem_addr_o = rst_ni ? addr_mux : '0;

   // State, owner and starvation counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         own_q    <= OWN_IF;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         own_q    <= own_d;
         starve_q <= starve_d;
      end
   end

   // Next state: record the winner on issue, track how often a waiting IF lost.
   always_comb begin
      state_d  = state_q;
      own_d    = own_q;
      starve_d = starve_q;
      if (issue_ok) begin
         if (any_req) begin
            state_d = ST_WAIT;
            own_d   = winner;
            if (winner == OWN_IF) begin
               starve_d = '0;
            end else if (if_req_i && (starve_q < STARVE_LIM)) begin
               starve_d = starve_q + STARVE_W'(1);
            end
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // Outputs: grants and strobe are combinational from the requests; everything
   // is held at zero while reset is asserted.
   always_comb begin
      mem_req_o    = 1'b0;
      if_gnt_o     = 1'b0;
      lsu_gnt_o    = 1'b0;
      if_rvalid_o  = 1'b0;
      lsu_rvalid_o = 1'b0;
      if_rdata_o   = '0;
      lsu_rdata_o  = '0;
      mem_we_o     = 1'b0;
      mem_wdata_o  = '0;
      mem_bmask_o  = '0;
      if (rst_ni) begin
         mem_req_o    = issuing;
         if_gnt_o     = issuing && (winner == OWN_IF);
         lsu_gnt_o    = issuing && (winner == OWN_LSU);
         if_rvalid_o  = (state_q == ST_WAIT) && mem_rvalid_i && (own_q == OWN_IF);
         lsu_rvalid_o = (state_q == ST_WAIT) && mem_rvalid_i && (own_q == OWN_LSU);
         if_rdata_o   = mem_rdata_i;
         lsu_rdata_o  = mem_rdata_i;
         if (sel_o) begin
            mem_we_o    = lsu_we_i;
            mem_wdata_o = lsu_wdata_i;
            mem_bmask_o = lsu_bmask_i;
         end else begin
            mem_we_o    = 1'b0;
            mem_wdata_o = '0;
            mem_bmask_o = '1;
         end
      end
   end

endmodule
